hex_scan_driver: RTL and testbench
==================================

Name: hex_scan_driver

Overview:
- Time-multiplexed scan driver for a multi-digit 7-segment display; sits directly upstream of the team's hex-to-7-segment decoder.
- Holds a frame-stable display value and walks the digits at a programmable refresh rate.
- Each cycle it presents the selected 4-bit nibble on code and drives an active-low one-hot digit enable.
- Loads new values tear-free, at frame boundaries only, with a one-cycle acknowledge; leading-zero blanking is optional.

Parameters:
- NUM_DIGITS, 4, number of display digits scanned (>=2).
- REFRESH_DIV, 50000, clk cycles each digit is held (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- value  input  4*NUM_DIGITS  hex value to display; nibble i maps to digit i, and digit 0 is least significant.
- load  input  1  single-cycle request to capture value.
- blank_lz  input  1  1 = blank leading-zero digits.
- code  output  4  nibble of current digit, feeds decoder code input.
- digit_en_n  output  NUM_DIGITS  active-low one-hot digit enable.
- blank  output  1  1 = current digit blanked.
- load_ack  output  1  one-cycle pulse when a captured value becomes displayed.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All state is on clk posedge, async clear on rst_n low.
- Reset values:
  - prescaler = 0, digit index = 0.
  - shadow (displayed value) = 0, pending register = 0, pend flag = 0.
  - code = 0, digit_en_n = all 1 except bit0 = 0, blank = 0, load_ack = 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. tick is asserted in the cycle the count equals REFRESH_DIV-1. With REFRESH_DIV = 1, tick is asserted every cycle.
- Digit index: advances by 1 on tick; wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle with tick = 1 and index = NUM_DIGITS-1.
- Load capture (load = 1 outside a boundary cycle):
  - value goes to the pending register; pend is set.
  - A repeated load before the boundary overwrites pending (latest wins); no ack is issued for the overwritten value.
- Apply at boundary:
  - If pend = 1 and load = 0: shadow <= pending, pend cleared.
  - If load = 1 in the boundary cycle: shadow <= value directly, bypassing and discarding pending; pend cleared.
  - In either case, load_ack = 1 in the following cycle, for exactly 1 cycle.
  - With no pending and no load at the boundary: shadow is held and no ack is issued.
- Outputs are registered and reflect the index and shadow after one cycle of latency:
  - code = shadow nibble[index].
  - digit_en_n = ~(1 << index).
- Leading-zero blanking, when blank_lz = 1:
  - A digit k > 0 is blanked when shadow nibbles k..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - A blanked digit drives digit_en_n = all 1, blank = 1, code = 0.
  - blank_lz is sampled every cycle; it is not frame-latched.
- Reset mid-operation: all state returns to reset values immediately, and any pending load is lost with no ack.
- No combinational path exists from inputs to outputs.

Test Plan (NUM_DIGITS = 4, REFRESH_DIV = 4):
- Reset release, no load -> code = 0 for every digit; digit_en_n cycles 1110, 1101, 1011, 0111, each held 4 clks, then wraps to 1110; blank = 0; load_ack never asserted.
- load with value = 16'h1A3F mid-frame -> display unchanged until the frame boundary; load_ack pulses 1 clk after the boundary; next frame code sequence is F, 3, A, 1.
- Two loads in one frame (16'h1111 then 16'h2222) -> only 2222 is shown; exactly one load_ack.
- load with value = 16'h00B5 in the boundary cycle -> bypass applies it; load_ack next cycle; next frame shows 5, B, 0, 0.
- blank_lz = 1 with shadow = 16'h00B5 -> digits 2 and 3 have blank = 1 and digit_en_n = 1111; with shadow = 0, only digit 0 is lit, showing 0.
- Assert rst_n low while pend = 1 at index 2 -> outputs return to reset values asynchronously; after release, shadow = 0 and no load_ack occurs.

Source files
------------

// File: rtl/hex_scan_driver.sv
// Time-multiplexed 7-segment scan driver: walks NUM_DIGITS digits at a
// programmable rate, swaps in new display values only at frame boundaries.
module hex_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              code,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    blank,
  output logic                    load_ack
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]                 cnt;
  logic [IW-1:0]                 idx;
  logic [NUM_DIGITS-1:0][3:0]    shadow, pending, val_n;
  logic [4*NUM_DIGITS-1:0]       shadow_f;
  logic [NUM_DIGITS-1:0]         zsuf;
  logic                          pend, tick, boundary, lz;

  assign val_n    = value;
  assign shadow_f = shadow;
  assign tick     = (cnt == CW'(REFRESH_DIV - 1));
  assign boundary = tick && (idx == IW'(NUM_DIGITS - 1));

  // zsuf[k]: every nibble from digit k up to the top is zero
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
    assign zsuf[k] = ~|(shadow_f >> (4 * k));
  end

  assign lz = blank_lz && (idx != '0) && zsuf[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      shadow     <= '0;
      pending    <= '0;
      pend       <= 1'b0;
      code       <= 4'h0;
      digit_en_n <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      blank      <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

      // A load coinciding with the boundary bypasses and discards pending
      if (boundary) begin
        if (load)      shadow <= val_n;
        else if (pend) shadow <= pending;
        pend <= 1'b0;
      end else if (load) begin
        pending <= val_n;
        pend    <= 1'b1;
      end
      load_ack <= boundary && (load || pend);

      code       <= lz ? 4'h0 : shadow[idx];
      digit_en_n <= lz ? '1 : ~(NUM_DIGITS'(1) << idx);
      blank      <= lz;
    end
  end
endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver; expected outputs are queued per driven
// cycle from a time-based frame model and compared when the DUT registers them.
module tb_hex_scan_driver;
  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  code;
  logic [3:0]  digit_en_n;
  logic        blank;
  logic        load_ack;

  hex_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
    .code(code), .digit_en_n(digit_en_n), .blank(blank), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] den;
    logic       blank;
    logic       ack;
  } exp_t;

  exp_t        sb[$];
  int          n;           // clock edges since reset release
  logic [15:0] m_shadow, m_pending;
  logic        m_pend;
  int          passed = 0;
  int          total  = 0;
  int          acks;

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s n=%0d got={code,den,blank,ack}=%b expected=%b", tag, n, got, exp);
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask

  // Drive one cycle of stimulus, predict the registered outputs, compare them.
  task automatic cyc(input string tag, input logic ld, input logic [15:0] v);
    exp_t e;
    int   d;
    logic bnd, z;
    load  = ld;
    value = v;
    d   = (n / RD) % ND;
    bnd = ((n % (RD * ND)) == (RD * ND - 1));
    z   = blank_lz && (d != 0) && ((m_shadow >> (4 * d)) == 16'h0);
    e.code  = z ? 4'h0 : m_shadow[4*d +: 4];
    e.den   = z ? 4'hF : ~(4'b0001 << d);
    e.blank = z;
    e.ack   = bnd && (ld || m_pend);
    sb.push_back(e);
    if (bnd) begin
      if (ld)          m_shadow = v;
      else if (m_pend) m_shadow = m_pending;
      m_pend = 1'b0;
    end else if (ld) begin
      m_pending = v;
      m_pend    = 1'b1;
    end
    n++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(tag, {code, digit_en_n, blank, load_ack}, e);
  endtask

  task automatic model_reset();
    n = 0; m_shadow = '0; m_pending = '0; m_pend = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_vals", {code, digit_en_n, blank, load_ack}, {4'h0, 4'b1110, 1'b0, 1'b0});
    rst_n = 1'b1;

    // Idle scan: all zeros, rotating enables, no ack
    repeat (20) cyc("scan", 1'b0, 16'h0);

    // Mid-frame load, shown from the next frame onwards
    cyc("ld_1a3f", 1'b1, 16'h1A3F);
    repeat (30) cyc("ld_1a3f", 1'b0, 16'h0);

    // Two loads in one frame: latest wins, one ack
    cyc("ld_twice", 1'b1, 16'h1111);
    repeat (3) cyc("ld_twice", 1'b0, 16'h0);
    cyc("ld_twice", 1'b1, 16'h2222);
    acks = 0;
    repeat (30) begin
      cyc("ld_twice", 1'b0, 16'h0);
      if (load_ack) acks++;
    end
    check_int("ld_twice_ack_count", acks, 1);

    // Load exactly in the boundary cycle bypasses pending
    while ((n % (RD * ND)) != RD * ND - 1) cyc("bypass", 1'b0, 16'h0);
    cyc("bypass", 1'b1, 16'h00B5);
    repeat (17) cyc("bypass", 1'b0, 16'h0);

    // Leading-zero blanking on 00B5, then on 0000
    blank_lz = 1'b1;
    repeat (16) cyc("blank_b5", 1'b0, 16'h0);
    while ((n % (RD * ND)) != RD * ND - 1) cyc("blank_zero", 1'b0, 16'h0);
    cyc("blank_zero", 1'b1, 16'h0000);
    repeat (16) cyc("blank_zero", 1'b0, 16'h0);
    blank_lz = 1'b0;
    repeat (4) cyc("unblank", 1'b0, 16'h0);

    // Async reset while a load is pending at digit 2
    while ((n % (RD * ND)) != 2) cyc("pre_rst", 1'b0, 16'h0);
    cyc("pre_rst", 1'b1, 16'h1234);
    while ((n % (RD * ND)) != 9) cyc("pre_rst", 1'b0, 16'h0);
    load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {code, digit_en_n, blank, load_ack}, {4'h0, 4'b1110, 1'b0, 1'b0});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    acks = 0;
    repeat (24) begin
      cyc("post_rst", 1'b0, 16'h0);
      if (load_ack) acks++;
    end
    check_int("post_rst_no_ack", acks, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
